// File: rtl/mult_seq_if.sv
// Handshake and shared-adder bundle between the control unit/ALU side and the
// mult_seq multiplier sequencer.
interface mult_seq_if;
  logic        start;
  logic        sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [5:0]  add_alufun;
  logic        add_sign;
  logic [31:0] add_s;

  modport master (
    output start, sign, op_a, op_b, add_s,
    input  busy, done, hi, lo, add_a, add_b, add_alufun, add_sign
  );

  modport slave (
    input  start, sign, op_a, op_b, add_s,
    output busy, done, hi, lo, add_a, add_b, add_alufun, add_sign
  );
endinterface

// File: rtl/mult_seq.sv
// MULT/MULTU shift-add sequencer driving the shared ALU adder; 64-bit {hi,lo}.
// Optional MULT_EARLY_EXIT_EN ends LOOP once the remaining multiplier bits are zero.
module mult_seq #(
  parameter logic [5:0] ALUFUN_ADD = 6'b000000,
  parameter logic [5:0] ALUFUN_SUB = 6'b000001
) (
  input logic       clk,
  input logic       reset,
  mult_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, LOOP, ALIGN, NEG_LO, NEG_HI, DONE
  } state_t;

  state_t      state;
  logic [31:0] m;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [4:0]  count;
  logic        neg;
  logic        sgn;
  logic        z;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  fun;
  logic        carry;
`ifdef MULT_EARLY_EXIT_EN
  logic [5:0]  rem;
`endif

  // The adder is used combinationally: operands depend only on the current state.
  always_comb begin
    a   = 32'd0;
    b   = 32'd0;
    fun = ALUFUN_ADD;
    case (state)
      NEG_A: begin
        b   = m;
        fun = ALUFUN_SUB;
      end
      NEG_B, NEG_LO: begin
        b   = p_lo;
        fun = ALUFUN_SUB;
      end
      LOOP: begin
        a = p_hi;
        b = p_lo[0] ? m : 32'd0;
      end
      NEG_HI: begin
        a = ~p_hi;
        b = {31'd0, z};
      end
      default: ;
    endcase
    carry = (a[31] & b[31]) | ((a[31] | b[31]) & ~bus.add_s[31]);
  end

  assign bus.add_a      = a;
  assign bus.add_b      = b;
  assign bus.add_alufun = fun;
  assign bus.add_sign   = 1'b0;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

  // Operands are converted to magnitudes, multiplied unsigned, then the
  // 64-bit result is negated back when the operand signs differed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      m      <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      count  <= 5'd0;
      neg    <= 1'b0;
      sgn    <= 1'b0;
      z      <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
`ifdef MULT_EARLY_EXIT_EN
      rem    <= 6'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            m      <= bus.op_a;
            p_lo   <= bus.op_b;
            p_hi   <= 32'd0;
            neg    <= bus.sign & (bus.op_a[31] ^ bus.op_b[31]);
            sgn    <= bus.sign;
            count  <= 5'd0;
            busy_q <= 1'b1;
            state  <= bus.sign ? NEG_A : LOOP;
          end
        end
        NEG_A: begin
          if (m[31]) m <= bus.add_s;
          state <= NEG_B;
        end
        NEG_B: begin
          if (p_lo[31]) p_lo <= bus.add_s;
          state <= LOOP;
        end
        LOOP: begin
`ifdef MULT_EARLY_EXIT_EN
          if ((p_lo & (32'hFFFF_FFFF >> count)) == 32'd0) begin
            rem   <= 6'd32 - {1'b0, count};
            state <= ALIGN;
          end else
`endif
          begin
            {p_hi, p_lo} <= {carry, bus.add_s, p_lo[31:1]};
            count        <= count + 5'd1;
            if (count == 5'd31) state <= sgn ? NEG_LO : DONE;
          end
        end
`ifdef MULT_EARLY_EXIT_EN
        ALIGN: begin
          {p_hi, p_lo} <= {p_hi, p_lo} >> rem;
          state        <= sgn ? NEG_LO : DONE;
        end
`endif
        NEG_LO: begin
          z <= (p_lo == 32'd0);
          if (neg) p_lo <= bus.add_s;
          state <= NEG_HI;
        end
        NEG_HI: begin
          if (neg) p_hi <= bus.add_s;
          state <= DONE;
        end
        DONE: begin
          hi_q   <= p_hi;
          lo_q   <= p_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed and random MULT/MULTU against a plain 64-bit
// multiply, with the shared adder modelled behaviourally.
module tb_mult_seq;

  localparam logic [5:0] ALUFUN_ADD = 6'b000000;
  localparam logic [5:0] ALUFUN_SUB = 6'b000001;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mult_seq_if bus ();

  mult_seq #(
    .ALUFUN_ADD(ALUFUN_ADD),
    .ALUFUN_SUB(ALUFUN_SUB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Shared ALU adder stand-in
  assign bus.add_s = (bus.add_alufun == ALUFUN_SUB) ? bus.add_a - bus.add_b
                                                    : bus.add_a + bus.add_b;

  function automatic logic [63:0] refProduct(input bit sgn, input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = sgn ? {{32{x[31]}}, x} : {32'd0, x};
    ey = sgn ? {{32{y[31]}}, y} : {32'd0, y};
    return ex * ey;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit sgn, input logic [31:0] x,
                               input logic [31:0] y, input bit poke);
    int          n;
    bit          seen;
    logic [63:0] exp;
    exp = refProduct(sgn, x, y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sign  = sgn;
    bus.op_a  = x;
    bus.op_b  = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
    checkOutput("busy_after_accept", 64'(bus.busy), 64'd1);
    checkOutput("first_add_b", 64'(bus.add_b), 64'(sgn ? x : (y[0] ? x : 32'd0)));
    checkOutput("first_alufun", 64'(bus.add_alufun), 64'(sgn ? ALUFUN_SUB : ALUFUN_ADD));
    n    = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
      else begin
        if (poke && n == 5) begin
          bus.start = 1'b1;
          bus.sign  = ~sgn;
          bus.op_a  = $urandom;
          bus.op_b  = $urandom;
        end
        if (n == 6) bus.start = 1'b0;
      end
    end
    checkOutput("done_latency", 64'(n), sgn ? 64'd37 : 64'd33);
    checkOutput("hi", 64'(bus.hi), 64'(exp[63:32]));
    checkOutput("lo", 64'(bus.lo), 64'(exp[31:0]));
    checkOutput("busy_low_with_done", 64'(bus.busy), 64'd0);
    checkOutput("add_sign_zero", 64'(bus.add_sign), 64'd0);
    @(posedge clk);
    #1 checkOutput("done_single_pulse", 64'(bus.done), 64'd0);
  endtask

  logic [31:0] edges [6];
  logic [31:0] ra;
  logic [31:0] rb;
  int          done_count;

  initial begin
    edges = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001};
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.op_a  = 32'd0;
    bus.op_b  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    checkOutput("rst_add_ab", {bus.add_a, bus.add_b}, 64'd0);
    checkOutput("rst_alufun", 64'(bus.add_alufun), 64'(ALUFUN_ADD));
    @(negedge clk) reset = 1'b0;

    // Directed cases with hand-computed products
    applyStimulus(1'b0, 32'h8000_0001, 32'h8000_0001, 1'b0);
    checkOutput("tp_multu_hilo", {bus.hi, bus.lo}, 64'h4000_0001_0000_0001);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("tp_multu_ff_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput("tp_mult_m1_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b1, 32'h8000_0001, 32'h8000_0001, 1'b0);
    checkOutput("tp_mult_sq_hilo", {bus.hi, bus.lo}, 64'h3FFF_FFFF_0000_0001);
    applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0002, 1'b0);
    checkOutput("tp_mult_zborrow_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_0000_0000);

    // Abort in the middle of LOOP
    @(negedge clk);
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk) reset = 1'b0;
    done_count = 0;
    repeat (45) begin
      @(posedge clk);
      #1 if (bus.done) done_count++;
    end
    checkOutput("no_done_after_abort", 64'(done_count), 64'd0);
    applyStimulus(1'b0, 32'd3, 32'd5, 1'b1);
    checkOutput("restart_hilo", {bus.hi, bus.lo}, 64'd15);

    // Random operands, with edge values mixed in
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) ra = edges[$urandom_range(0, 5)];
      if (i % 4 == 2) rb = edges[$urandom_range(0, 5)];
      applyStimulus(i[0], ra, rb, (i % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
